// File: rtl/scc_run_controller.sv
// scc_run_controller: sequences reset, run and stop of the SCC core, counting run cycles
// and folding the instruction/data buses into a 32-bit signature.
`default_nettype none

module scc_run_controller #(
    parameter int RST_CYCLES = 3,
    parameter int MAX_CYCLES = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             core_halt_f_i,
    input  logic [1:0]       core_err_bits_i,
    input  logic [31:0]      core_instr_v_i,
    input  logic [31:0]      core_dmem_v_i,
    output logic             core_rst_o,
    output logic             core_clk_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [31:0]      signature_o
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

    localparam logic [RW-1:0]    C_RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [CNT_W:0]   C_MAX      = (CNT_W + 1)'(MAX_CYCLES);
    localparam logic [1:0]       ST_NONE    = 2'b00;
    localparam logic [1:0]       ST_HALT    = 2'b01;
    localparam logic [1:0]       ST_ERR     = 2'b10;
    localparam logic [1:0]       ST_TMO     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      sig_q, sig_d;
    logic [1:0]       status_q, status_d;
    logic             core_rst_q, core_clk_en_q, busy_q, done_q;

    logic [CNT_W:0]   w_cnt_inc;
    assign w_cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        sig_d     = sig_q;
        status_d  = status_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d   = S_RESET;
                        rst_cnt_d = '0;
                        cnt_d     = '0;
                        sig_d     = '0;
                        status_d  = ST_NONE;
                    end
                end
                S_RESET: begin
                    if (rst_cnt_q == C_RST_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                S_RUN: begin
                    // Unlimited runs saturate; bounded runs exit before wrapping.
                    if (MAX_CYCLES == 0 && (&cnt_q)) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = w_cnt_inc[CNT_W-1:0];
                    end
                    sig_d = {sig_q[30:0], sig_q[31]} ^ core_instr_v_i ^ core_dmem_v_i;
                    if (core_err_bits_i != 2'b00) begin
                        state_d  = S_DONE;
                        status_d = ST_ERR;
                    end else if (core_halt_f_i) begin
                        state_d  = S_DONE;
                        status_d = ST_HALT;
                    end else if (MAX_CYCLES != 0 && w_cnt_inc == C_MAX) begin
                        state_d  = S_DONE;
                        status_d = ST_TMO;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet still Moore.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= '0;
            cnt_q         <= '0;
            sig_q         <= '0;
            status_q      <= ST_NONE;
            core_rst_q    <= 1'b1;
            core_clk_en_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cnt_q         <= cnt_d;
            sig_q         <= sig_d;
            status_q      <= status_d;
            core_rst_q    <= (state_d == S_IDLE) || (state_d == S_RESET);
            core_clk_en_q <= (state_d == S_RESET) || (state_d == S_RUN);
            busy_q        <= (state_d == S_RESET) || (state_d == S_RUN);
            done_q        <= (state_d == S_DONE);
        end
    end

    assign core_rst_o    = core_rst_q;
    assign core_clk_en_o = core_clk_en_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign status_o      = status_q;
    assign cycle_count_o = cnt_q;
    assign signature_o   = sig_q;

endmodule

`default_nettype wire

// File: tb/tb_scc_run_controller.sv
// tb_scc_run_controller: directed vectors with hand-computed expectations for scc_run_controller.
`default_nettype none

module tb_scc_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i, core_halt_f_i;
    logic [1:0]  core_err_bits_i;
    logic [31:0] core_instr_v_i, core_dmem_v_i;
    logic        core_rst_o, core_clk_en_o, busy_o, done_o;
    logic [1:0]  status_o;
    logic [15:0] cycle_count_o;
    logic [31:0] signature_o;

    int n_vec = 0;
    int n_err = 0;

    scc_run_controller #(.RST_CYCLES(3), .MAX_CYCLES(15), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .core_halt_f_i   (core_halt_f_i),
        .core_err_bits_i (core_err_bits_i),
        .core_instr_v_i  (core_instr_v_i),
        .core_dmem_v_i   (core_dmem_v_i),
        .core_rst_o      (core_rst_o),
        .core_clk_en_o   (core_clk_en_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .status_o        (status_o),
        .cycle_count_o   (cycle_count_o),
        .signature_o     (signature_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".core_rst"}, 32'(core_rst_o), 32'd1);
        chk({tag, ".clk_en"},   32'(core_clk_en_o), 32'd0);
        chk({tag, ".busy"},     32'(busy_o), 32'd0);
        chk({tag, ".done"},     32'(done_o), 32'd0);
        chk({tag, ".status"},   32'(status_o), 32'd0);
        chk({tag, ".count"},    32'(cycle_count_o), 32'd0);
        chk({tag, ".sig"},      signature_o, 32'd0);
    endtask

    // Start, then walk through the reset hold into RUN (3 RESET clocks).
    task automatic go_run(input string tag);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk({tag, ".rst_hold0"}, 32'(core_rst_o), 32'd1);
        chk({tag, ".rst_clken"}, 32'(core_clk_en_o), 32'd1);
        chk({tag, ".cnt_clr"},   32'(cycle_count_o), 32'd0);
        step();
        step();
        chk({tag, ".rst_hold2"}, 32'(core_rst_o), 32'd1);
        step();
        chk({tag, ".rst_fall"},  32'(core_rst_o), 32'd0);
        chk({tag, ".run_busy"},  32'(busy_o), 32'd1);
    endtask

    task automatic run_timeout(input string tag, input bit poke_start);
        go_run(tag);
        for (int i = 1; i <= 14; i++) begin
            if (poke_start && i == 7) start_i = 1'b1;
            step();
            start_i = 1'b0;
        end
        chk({tag, ".cnt14"},   32'(cycle_count_o), 32'd14);
        chk({tag, ".busy14"},  32'(busy_o), 32'd1);
        step();
        chk({tag, ".done"},    32'(done_o), 32'd1);
        chk({tag, ".status"},  32'(status_o), 32'd3);
        chk({tag, ".count"},   32'(cycle_count_o), 32'd15);
        chk({tag, ".clk_en"},  32'(core_clk_en_o), 32'd0);
        chk({tag, ".core_rst"},32'(core_rst_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0; abort_i = 1'b0; core_halt_f_i = 1'b0;
        core_err_bits_i = 2'b00; core_instr_v_i = '0; core_dmem_v_i = '0;
        step();
        step();
        chk_reset_vals("por");
        rst = 1'b0;
        step();
        chk("idle.core_rst", 32'(core_rst_o), 32'd1);

        // Timeout run
        run_timeout("t2", 1'b0);
        step();
        chk("t2.done_hold", 32'(done_o), 32'd1);

        // Signature then halt on 5th RUN edge
        go_run("t5");
        core_instr_v_i = 32'h1;
        step();
        chk("t5.sig1", signature_o, 32'h1);
        step();
        chk("t5.sig2", signature_o, 32'h3);
        core_instr_v_i = 32'h0;
        core_dmem_v_i  = 32'h10;
        step();
        chk("t5.sig3", signature_o, 32'h16);
        core_dmem_v_i = 32'h0;
        step();
        core_halt_f_i = 1'b1;
        step();
        core_halt_f_i = 1'b0;
        chk("t3.status", 32'(status_o), 32'd1);
        chk("t3.count",  32'(cycle_count_o), 32'd5);
        chk("t3.clk_en", 32'(core_clk_en_o), 32'd0);
        chk("t3.sig",    signature_o, 32'h58);

        // Error beats halt
        go_run("t4a");
        core_err_bits_i = 2'b10;
        core_halt_f_i   = 1'b1;
        step();
        core_err_bits_i = 2'b00;
        core_halt_f_i   = 1'b0;
        chk("t4a.status", 32'(status_o), 32'd2);
        chk("t4a.count",  32'(cycle_count_o), 32'd1);
        chk("t4a.done",   32'(done_o), 32'd1);

        // Halt beats timeout
        go_run("t4b");
        repeat (14) step();
        core_halt_f_i = 1'b1;
        step();
        core_halt_f_i = 1'b0;
        chk("t4b.status", 32'(status_o), 32'd1);
        chk("t4b.count",  32'(cycle_count_o), 32'd15);

        // Abort mid-run holds counters
        go_run("t6");
        repeat (4) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("t6.core_rst", 32'(core_rst_o), 32'd1);
        chk("t6.busy",     32'(busy_o), 32'd0);
        chk("t6.count",    32'(cycle_count_o), 32'd4);
        chk("t6.clk_en",   32'(core_clk_en_o), 32'd0);
        start_i = 1'b1;
        abort_i = 1'b1;
        step();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("t6.abort_wins", 32'(busy_o), 32'd0);
        chk("t6.cnt_kept",   32'(cycle_count_o), 32'd4);
        run_timeout("t6r", 1'b1);

        // Asynchronous reset mid-run, checked before any clock edge
        go_run("t1");
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("t1");
        #1;
        rst = 1'b0;
        step();
        chk("t1.after", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
